rr_grant_ctrl_8ch: RTL and testbench
====================================

Name: rr_grant_ctrl_8ch

Overview:
- Round-robin arbiter/scheduler that shares one 8-way resource among 8 requesters.
- Each grant is issued both as a 3-bit select index and as its decoded one-hot strobe.
- The one-hot strobe is the enable vector the downstream 3x8 decode path drives.
- Features: one grant at a time, rotating priority, bounded hold time with forced release.

Parameters:
- HOLD_W, 4: width of the hold-cycle counter.
- MAX_HOLD, 15: maximum consecutive cycles a grant may be held. Legal range 1..2^HOLD_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  current owner releases the resource; sampled only while gnt_valid=1.
- gnt_valid  output  1  a grant is active this cycle.
- gnt_idx  output  3  index of the granted requester.
- gnt_onehot  output  8  one-hot of gnt_idx when gnt_valid=1, else 8'h00.
- timeout  output  1  one-cycle pulse flagging a forced release at MAX_HOLD.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (applied immediately on rst, including mid-grant):
  - state=IDLE, ptr=3'd0, hold_cnt=0.
  - gnt_valid=0, gnt_idx=3'd0, gnt_onehot=8'h00, timeout=0.
- All outputs come from registers. There is no combinational path from req or done to any output.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req, searching ptr, ptr+1, ..., ptr+7 (mod 8).
  - At the clock edge: gnt_idx<=selected, gnt_valid<=1, hold_cnt<=1, state<=GRANT.
  - Latency: req sampled high in IDLE -> gnt_valid=1 on the next cycle.
- GRANT, evaluated each edge in priority order:
  1. done=1 -> normal release.
  2. req[gnt_idx]=0 -> normal release (requester withdrew).
  3. hold_cnt==MAX_HOLD -> forced release; timeout<=1 for exactly one cycle, concurrent with the first IDLE cycle.
  4. Otherwise stay in GRANT; hold_cnt<=hold_cnt+1.
- Any release:
  - state<=IDLE, gnt_valid<=0, ptr<=gnt_idx+1 (7 wraps to 0).
  - gnt_idx keeps its last value; gnt_onehot=8'h00.
- Back-to-back grants always have exactly one gnt_valid=0 cycle between them. That IDLE cycle performs arbitration with the updated ptr.
- Simultaneous events:
  - If done=1 in the same cycle hold_cnt==MAX_HOLD, this is a normal release and timeout stays 0.
  - Changes to req bits other than gnt_idx during GRANT have no effect.
- Fairness: a requester holding req high is granted within 7 intervening grants.
- gnt_onehot has at most one bit set, always equal to 1<<gnt_idx while gnt_valid=1.
- timeout is never high while gnt_valid=1.

Test Plan:
- Reset, then req=8'h00 for 10 cycles -> gnt_valid=0, gnt_onehot=8'h00 and timeout=0 throughout. Assert rst mid-grant -> all outputs zero immediately, without waiting for clk.
- Single requester: req=8'h08 -> gnt_valid=1, gnt_idx=3, gnt_onehot=8'h08 one cycle later. done pulse -> next cycle gnt_valid=0, ptr=4.
- Rotation: req=8'hFF held, done pulsed 1 cycle after each grant -> gnt_idx sequence 0,1,2,...,7,0 with exactly one idle cycle between grants.
- Wrap and priority: ptr=7 (after a grant to 6), req=8'h41 -> grant idx 0 (search order 7,0,...,6). Next grant goes to idx 6.
- Timeout: req=8'h04 held, done=0 -> gnt_valid=1 for exactly 15 cycles, then timeout=1 for one cycle with gnt_valid=0. Regrant to idx 2 follows the cycle after that.
- Collision at the limit: done=1 exactly on the 15th grant cycle -> release with timeout=0. Withdrawal test: drop req[gnt_idx] mid-grant -> release the next edge.

Source files
------------

// File: rtl/rr_grant_ctrl_8ch_if.sv
// rr_grant_ctrl_8ch_if: request/release handshake and grant outputs of the 8-way round-robin arbiter.
interface rr_grant_ctrl_8ch_if;
  logic [7:0] req;
  logic       done;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt_onehot;
  logic       timeout;
  modport master (output req, done, input gnt_valid, gnt_idx, gnt_onehot, timeout);
  modport slave (input req, done, output gnt_valid, gnt_idx, gnt_onehot, timeout);
endinterface

// File: rtl/rr_grant_ctrl_8ch.sv
// rr_grant_ctrl_8ch: round-robin arbiter for 8 requesters with bounded hold time and forced release.
module rr_grant_ctrl_8ch #(
  parameter int HOLD_W   = 4,
  parameter int MAX_HOLD = 15
) (
  input logic             clk,
  input logic             rst,
  rr_grant_ctrl_8ch_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t            state, state_n;
  logic [2:0]        ptr, ptr_n, idx, idx_n, off, sel;
  logic [HOLD_W-1:0] hold, hold_n;
  logic [7:0]        oh, oh_n;
  logic              valid, valid_n, to, to_n;
  logic              at_max, owner_req, rel;
  // Highest priority goes to ptr; the 3-bit index sum wraps the search naturally.
  always_comb begin
    off = '0;
    for (int i = 7; i >= 0; i--) if (bus.req[ptr + 3'(i)]) off = 3'(i);
  end
  assign sel       = ptr + off;
  assign at_max    = hold == HOLD_W'(MAX_HOLD);
  assign owner_req = bus.req[idx];
  assign rel       = bus.done || !owner_req || at_max;
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hold_n  = hold;
    idx_n   = idx;
    valid_n = 1'b0;
    oh_n    = 8'h00;
    to_n    = 1'b0;
    if (state == IDLE) begin
      if (|bus.req) begin
        state_n = GRANT;
        idx_n   = sel;
        valid_n = 1'b1;
        hold_n  = HOLD_W'(1);
        oh_n    = 8'h01 << sel;
      end
    end else if (rel) begin
      state_n = IDLE;
      ptr_n   = idx + 3'd1;
      to_n    = !bus.done && owner_req && at_max;
    end else begin
      hold_n  = hold + HOLD_W'(1);
      valid_n = 1'b1;
      oh_n    = oh;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      hold  <= '0;
      idx   <= '0;
      valid <= 1'b0;
      oh    <= 8'h00;
      to    <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      hold  <= hold_n;
      idx   <= idx_n;
      valid <= valid_n;
      oh    <= oh_n;
      to    <= to_n;
    end
  end
  assign bus.gnt_valid  = valid;
  assign bus.gnt_idx    = idx;
  assign bus.gnt_onehot = oh;
  assign bus.timeout    = to;
endmodule

// File: tb/tb_rr_grant_ctrl_8ch.sv
// tb_rr_grant_ctrl_8ch: directed checks of arbitration order, hold limit, release and reset.
module tb_rr_grant_ctrl_8ch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  rr_grant_ctrl_8ch_if bus ();
  rr_grant_ctrl_8ch #(.HOLD_W(4), .MAX_HOLD(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic test_reset();
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout} !== 13'd0) begin
      failed++;
      $display("FAIL reset_values: got v=%b idx=%0d oh=%h to=%b, want all zero", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.gnt_valid, bus.gnt_onehot, bus.timeout} !== 10'd0) begin
        failed++;
        $display("FAIL idle_no_req cycle %0d: got v=%b oh=%h to=%b, want 0/00/0", c, bus.gnt_valid, bus.gnt_onehot, bus.timeout);
      end
    end
  endtask

  task automatic test_single();
    bus.req = 8'h08;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout} !== {1'b1, 3'd3, 8'h08, 1'b0}) begin
      failed++;
      $display("FAIL single_grant: got v=%b idx=%0d oh=%h to=%b, want 1/3/08/0", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
    end
    bus.done = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout} !== {1'b0, 3'd3, 8'h00, 1'b0}) begin
      failed++;
      $display("FAIL single_release: got v=%b idx=%0d oh=%h to=%b, want 0/3/00/0", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
    end
    bus.done = 1'b0;
    bus.req  = 8'h09;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      failed++;
      $display("FAIL ptr_after_3: got v=%b idx=%0d oh=%h, want 1/0/01", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'(k % 8), 8'h01 << (k % 8)}) begin
        failed++;
        $display("FAIL rotation grant %0d: got v=%b idx=%0d oh=%h, want 1/%0d", k, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, k % 8);
      end
      bus.done = 1'b1;
      @(negedge clk);
      tests++;
      if ({bus.gnt_valid, bus.gnt_onehot} !== 9'd0) begin
        failed++;
        $display("FAIL rotation gap %0d: got v=%b oh=%h, want 0/00", k, bus.gnt_valid, bus.gnt_onehot);
      end
      bus.done = 1'b0;
      if (k == 8) bus.req = 8'h00;
    end
    @(negedge clk);
  endtask

  task automatic test_wrap_priority();
    bus.req = 8'h40;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx} !== {1'b1, 3'd6}) begin
      failed++;
      $display("FAIL wrap_setup: got v=%b idx=%0d, want 1/6", bus.gnt_valid, bus.gnt_idx);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 8'h41;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      failed++;
      $display("FAIL wrap_from_7: got v=%b idx=%0d oh=%h, want 1/0/01", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd6, 8'h40}) begin
      failed++;
      $display("FAIL wrap_next: got v=%b idx=%0d oh=%h, want 1/6/40", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bus.req = 8'h04;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      tests++;
      if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout} !== {1'b1, 3'd2, 8'h04, 1'b0}) begin
        failed++;
        $display("FAIL timeout_hold cycle %0d: got v=%b idx=%0d oh=%h to=%b, want 1/2/04/0", c, bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
      end
    end
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_onehot, bus.timeout} !== {1'b0, 8'h00, 1'b1}) begin
      failed++;
      $display("FAIL timeout_pulse: got v=%b oh=%h to=%b, want 0/00/1", bus.gnt_valid, bus.gnt_onehot, bus.timeout);
    end
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.timeout} !== {1'b1, 3'd2, 1'b0}) begin
      failed++;
      $display("FAIL timeout_regrant: got v=%b idx=%0d to=%b, want 1/2/0", bus.gnt_valid, bus.gnt_idx, bus.timeout);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_collision();
    bus.req = 8'h04;
    for (int c = 1; c <= 15; c++) @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx} !== {1'b1, 3'd2}) begin
      failed++;
      $display("FAIL collision_15th: got v=%b idx=%0d, want 1/2", bus.gnt_valid, bus.gnt_idx);
    end
    bus.done = 1'b1;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_onehot, bus.timeout} !== {1'b0, 8'h00, 1'b0}) begin
      failed++;
      $display("FAIL collision_release: got v=%b oh=%h to=%b, want 0/00/0", bus.gnt_valid, bus.gnt_onehot, bus.timeout);
    end
    bus.done = 1'b0;
    bus.req  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    bus.req = 8'h30;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd4, 8'h10}) begin
      failed++;
      $display("FAIL withdraw_grant: got v=%b idx=%0d oh=%h, want 1/4/10", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.req = 8'h31;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd4, 8'h10}) begin
      failed++;
      $display("FAIL other_req_change: got v=%b idx=%0d oh=%h, want 1/4/10", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.req = 8'h20;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_onehot, bus.timeout} !== {1'b0, 8'h00, 1'b0}) begin
      failed++;
      $display("FAIL withdraw_release: got v=%b oh=%h to=%b, want 0/00/0", bus.gnt_valid, bus.gnt_onehot, bus.timeout);
    end
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx} !== {1'b1, 3'd5}) begin
      failed++;
      $display("FAIL withdraw_next: got v=%b idx=%0d, want 1/5", bus.gnt_valid, bus.gnt_idx);
    end
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bus.req = 8'h81;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd7, 8'h80}) begin
      failed++;
      $display("FAIL pre_reset_grant: got v=%b idx=%0d oh=%h, want 1/7/80", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout} !== 13'd0) begin
      failed++;
      $display("FAIL async_reset: got v=%b idx=%0d oh=%h to=%b, want all zero", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot, bus.timeout);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot} !== {1'b1, 3'd0, 8'h01}) begin
      failed++;
      $display("FAIL ptr_after_reset: got v=%b idx=%0d oh=%h, want 1/0/01", bus.gnt_valid, bus.gnt_idx, bus.gnt_onehot);
    end
    bus.req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap_priority();
    test_timeout();
    test_collision();
    test_withdraw();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
